// File: rtl/conv_frame_ctrl_pkg.sv
// Shared definitions for the convolutional-encoder frame sequencer:
// FSM encodings, encoder constraint length and the derived flush length.
package conv_frame_ctrl_pkg;

    localparam int CONV_K        = 3;
    localparam int CONV_TAIL_LEN = CONV_K - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_DATA  = 3'd2,
        ST_TAIL  = 3'd3,
        ST_GAP   = 3'd4
    } frame_state_e;

    // Terminal count for a phase of 'len' cycles; a zero-length phase is never entered.
    function automatic int last_index(input int len);
        return (len > 0) ? len - 1 : 0;
    endfunction

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// Handshake and status bundle between the frame sequencer (master) and the
// surrounding source / encoder / modulator logic (slave).
interface conv_frame_ctrl_if #(
    parameter int FCNT_W = 16
);

    logic              start_sig;
    logic              stop_sig;
    logic              src_bit_sig;
    logic              src_ready_sig;
    logic              mod_ready_sig;
    logic              enc_en_sig;
    logic              enc_bit_sig;
    logic              enc_clr_sig;
    logic              sof_sig;
    logic              eof_sig;
    logic              busy_sig;
    logic [FCNT_W-1:0] frame_cnt_sig;

    modport master (
        input  start_sig,
        input  stop_sig,
        input  src_bit_sig,
        input  mod_ready_sig,
        output src_ready_sig,
        output enc_en_sig,
        output enc_bit_sig,
        output enc_clr_sig,
        output sof_sig,
        output eof_sig,
        output busy_sig,
        output frame_cnt_sig
    );

    modport slave (
        output start_sig,
        output stop_sig,
        output src_bit_sig,
        output mod_ready_sig,
        input  src_ready_sig,
        input  enc_en_sig,
        input  enc_bit_sig,
        input  enc_clr_sig,
        input  sof_sig,
        input  eof_sig,
        input  busy_sig,
        input  frame_cnt_sig
    );

endinterface

// File: rtl/conv_frame_ctrl_tc_counter.sv
// Up-counter with synchronous load-to-zero, count enable and a terminal-count
// flag against a run-time selectable last value.
module tc_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_sig,
    input  logic             rst_sig,
    input  logic             clr_sig,
    input  logic             en_sig,
    input  logic [WIDTH-1:0] last_sig,
    output logic             tc_sig,
    output logic             zero_sig
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear has priority so a phase change always restarts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_sig) begin
            cnt_d = '0;
        end else if (en_sig) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_sig or posedge rst_sig) begin
        if (rst_sig) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_sig   = (cnt_q == last_sig);
    assign zero_sig = (cnt_q == '0);

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the convolutional encoder: clear, payload, zero-tail flush
// and inter-frame gap, with back-pressure, SOF/EOF markers and a frame counter.
module conv_frame_ctrl
    import conv_frame_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = 32,
    parameter int TAIL_LEN  = CONV_TAIL_LEN,
    parameter int GAP_LEN   = 4,
    parameter int CNT_W     = 8,
    parameter int FCNT_W    = 16
) (
    input  logic                    clk_sig,
    input  logic                    rst_sig,
    conv_frame_ctrl_if.master       bus
);

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(last_index(FRAME_LEN));
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(last_index(TAIL_LEN));
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(last_index(GAP_LEN));

    frame_state_e      state_q;
    frame_state_e      state_d;
    logic              stop_q;
    logic              stop_d;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [FCNT_W-1:0] frame_cnt_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt_last;
    logic              cnt_tc;
    logic              cnt_zero;

    logic              stop_seen;
    frame_state_e      gap_exit_state;

    logic              enc_en;
    logic              enc_bit;
    logic              enc_clr;
    logic              src_ready;
    logic              sof;
    logic              eof;

    tc_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk_sig  (clk_sig),
        .rst_sig  (rst_sig),
        .clr_sig  (cnt_clr),
        .en_sig   (cnt_en),
        .last_sig (cnt_last),
        .tc_sig   (cnt_tc),
        .zero_sig (cnt_zero)
    );

    // A stop raised in the very cycle of the gap-end decision still counts.
    assign stop_seen      = stop_q | bus.stop_sig;
    assign gap_exit_state = (stop_seen || !bus.start_sig) ? ST_IDLE : ST_CLEAR;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        cnt_last    = DATA_LAST;
        enc_en      = 1'b0;
        enc_bit     = 1'b0;
        enc_clr     = 1'b0;
        src_ready   = 1'b0;
        sof         = 1'b0;
        eof         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.start_sig) begin
                    state_d = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                enc_clr = 1'b1;
                cnt_clr = 1'b1;
                state_d = ST_DATA;
            end

            ST_DATA: begin
                cnt_last = DATA_LAST;
                if (bus.mod_ready_sig) begin
                    enc_en    = 1'b1;
                    enc_bit   = bus.src_bit_sig;
                    src_ready = 1'b1;
                    sof       = cnt_zero;
                    if (cnt_tc) begin
                        cnt_clr = 1'b1;
                        state_d = ST_TAIL;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end

            ST_TAIL: begin
                cnt_last = TAIL_LAST;
                if (bus.mod_ready_sig) begin
                    enc_en = 1'b1;
                    if (cnt_tc) begin
                        eof         = 1'b1;
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                        cnt_clr     = 1'b1;
                        state_d     = (GAP_LEN == 0) ? gap_exit_state : ST_GAP;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end

            // The gap is a fixed idle time and does not wait on the modulator.
            ST_GAP: begin
                cnt_last = GAP_LAST;
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    state_d = gap_exit_state;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        stop_d = (state_d == ST_IDLE) ? 1'b0 : stop_seen;
    end

    always_ff @(posedge clk_sig or posedge rst_sig) begin
        if (rst_sig) begin
            state_q     <= ST_IDLE;
            stop_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stop_q      <= stop_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.enc_en_sig    = enc_en;
    assign bus.enc_bit_sig   = enc_bit;
    assign bus.enc_clr_sig   = enc_clr;
    assign bus.src_ready_sig = src_ready;
    assign bus.sof_sig       = sof;
    assign bus.eof_sig       = eof;
    assign bus.busy_sig      = (state_q != ST_IDLE);
    assign bus.frame_cnt_sig = frame_cnt_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: a scenario table plus hand-written
// reset and counter-wrap sequences, with a beat-by-beat scoreboard on the encoder port.
module tb_conv_frame_ctrl;

    localparam int FRAME_LEN = 8;
    localparam int TAIL_LEN  = 2;
    localparam int GAP_LEN   = 2;
    localparam int CNT_W     = 8;
    localparam int FCNT_W    = 16;
    localparam int BEAT_LEN  = FRAME_LEN + TAIL_LEN;
    localparam int PERIOD    = 1 + BEAT_LEN + GAP_LEN;

    typedef struct {
        logic bitv;
        logic sof;
        logic eof;
    } beat_t;

    typedef struct {
        int nFrames;
        bit stopWithStart;
        int stopAt;
        int stallAt;
        int stallLen;
        int expLatency;
        int expPeriod;
        int expSpan;
    } vec_t;

    logic clk_sig = 1'b0;
    logic rst_sig;

    always #5 clk_sig = ~clk_sig;

    conv_frame_ctrl_if #(.FCNT_W(FCNT_W)) dif ();
    conv_frame_ctrl_if #(.FCNT_W(2))      wif ();

    conv_frame_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .TAIL_LEN  (TAIL_LEN),
        .GAP_LEN   (GAP_LEN),
        .CNT_W     (CNT_W),
        .FCNT_W    (FCNT_W)
    ) dut (
        .clk_sig (clk_sig),
        .rst_sig (rst_sig),
        .bus     (dif.master)
    );

    // Second copy with a 2-bit frame counter, fed the same inputs, to see the wrap.
    conv_frame_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .TAIL_LEN  (TAIL_LEN),
        .GAP_LEN   (GAP_LEN),
        .CNT_W     (CNT_W),
        .FCNT_W    (2)
    ) dut_wrap (
        .clk_sig (clk_sig),
        .rst_sig (rst_sig),
        .bus     (wif.master)
    );

    logic  srcMem [0:1023];
    int    srcIdx = 0;
    int    pushIdx = 0;
    beat_t expQ [$];
    beat_t expBeat;
    int    clrHist [$];
    int    eofHist [$];

    int cycle = 0;
    int clrCount = 0, srcCount = 0, encCount = 0, sofCount = 0, eofCount = 0, frameEnc = 0;
    int clrBase, eofBase, srcBase, encBase, sofBase;
    int expFrameCnt = 0;
    int errors = 0;
    int checks = 0;

    assign dif.src_bit_sig   = srcMem[srcIdx % 1024];
    assign wif.start_sig     = dif.start_sig;
    assign wif.stop_sig      = dif.stop_sig;
    assign wif.src_bit_sig   = dif.src_bit_sig;
    assign wif.mod_ready_sig = dif.mod_ready_sig;

    // Monitor: outputs sampled on the falling edge; every encoder beat is
    // matched against the next expected beat from the scoreboard.
    always @(negedge clk_sig) begin
        cycle++;
        if (!rst_sig) begin
            if (dif.enc_clr_sig) begin
                clrCount++;
                frameEnc = 0;
                clrHist.push_back(cycle);
            end
            if (dif.enc_en_sig) begin
                encCount++;
                frameEnc++;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL beat: unexpected enc_en at cycle %0d, required no beat", cycle);
                end else begin
                    expBeat = expQ.pop_front();
                    if ({dif.enc_bit_sig, dif.sof_sig, dif.eof_sig} !== {expBeat.bitv, expBeat.sof, expBeat.eof}) begin
                        errors++;
                        $display("[TB] FAIL beat bit/sof/eof at cycle %0d: got %b%b%b, required %b%b%b", cycle,
                                 dif.enc_bit_sig, dif.sof_sig, dif.eof_sig, expBeat.bitv, expBeat.sof, expBeat.eof);
                    end
                end
            end
            if (dif.src_ready_sig) begin
                srcCount++;
                srcIdx++;
            end
            if (dif.sof_sig) sofCount++;
            if (dif.eof_sig) begin
                eofCount++;
                eofHist.push_back(cycle);
            end
            if (dif.src_ready_sig || dif.sof_sig || dif.eof_sig) begin
                checks++;
                if (!dif.enc_en_sig) begin
                    errors++;
                    $display("[TB] FAIL marker at cycle %0d: got enc_en=0 with src_ready/sof/eof, required enc_en=1", cycle);
                end
            end
        end
    end

    task automatic checkEq(input string name, input longint actual, input longint required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic pushFrames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < BEAT_LEN; b++) begin
                beat_t bt;
                bt.bitv = (b < FRAME_LEN) ? srcMem[pushIdx % 1024] : 1'b0;
                bt.sof  = (b == 0);
                bt.eof  = (b == BEAT_LEN - 1);
                if (b < FRAME_LEN) pushIdx++;
                expQ.push_back(bt);
            end
        end
    endtask

    task automatic takeBaselines();
        clrBase = clrCount;
        eofBase = eofCount;
        srcBase = srcCount;
        encBase = encCount;
        sofBase = sofCount;
    endtask

    task automatic applyStimulus(input vec_t v);
        bit finished  = 0;
        bit stallDone = 0;
        bit stopDone  = 0;
        bit inFrame;
        int stallLeft = 0;
        takeBaselines();
        pushFrames(v.nFrames);
        @(posedge clk_sig); #1;
        dif.start_sig = 1'b1;
        dif.stop_sig  = v.stopWithStart;
        for (int cyc = 0; cyc < 20 * PERIOD && !finished; cyc++) begin
            @(posedge clk_sig); #1;
            if (stallLeft > 0) begin
                stallLeft--;
                if (stallLeft == 0) dif.mod_ready_sig = 1'b1;
            end
            if (v.stopWithStart && cyc == 0) begin
                dif.start_sig = 1'b0;
                dif.stop_sig  = 1'b0;
            end else if (v.stopAt < 0 && eofCount - eofBase >= v.nFrames) begin
                dif.start_sig = 1'b0;
            end
            if (stopDone) dif.stop_sig = 1'b0;
            inFrame = (clrCount > clrBase) && (eofCount == eofBase);
            if (inFrame && !stallDone && v.stallAt >= 0 && frameEnc == v.stallAt) begin
                dif.mod_ready_sig = 1'b0;
                stallLeft = v.stallLen;
                stallDone = 1;
            end
            if (inFrame && !stopDone && v.stopAt >= 0 && frameEnc == v.stopAt) begin
                dif.stop_sig = 1'b1;
                stopDone = 1;
            end
            if (eofCount - eofBase >= v.nFrames && !dif.busy_sig) finished = 1;
        end
        dif.start_sig     = 1'b0;
        dif.stop_sig      = 1'b0;
        dif.mod_ready_sig = 1'b1;
        checkEq("scenario completes before timeout", finished, 1);
    endtask

    task automatic checkOutput(input vec_t v);
        checkEq("src_ready pulses", srcCount - srcBase, v.nFrames * FRAME_LEN);
        checkEq("enc_en pulses", encCount - encBase, v.nFrames * BEAT_LEN);
        checkEq("enc_clr pulses", clrCount - clrBase, v.nFrames);
        checkEq("sof count", sofCount - sofBase, v.nFrames);
        checkEq("eof count", eofCount - eofBase, v.nFrames);
        checkEq("scoreboard drained", expQ.size(), 0);
        expFrameCnt += v.nFrames;
        checkEq("frame_cnt", dif.frame_cnt_sig, expFrameCnt % 65536);
        checkEq("frame_cnt 2-bit wrap", wif.frame_cnt_sig, expFrameCnt % 4);
        checkEq("busy after frames", dif.busy_sig, 0);
        if (eofCount > eofBase && clrCount > clrBase)
            checkEq("clr-to-eof latency", eofHist[eofBase] - clrHist[clrBase], v.expLatency);
        if (v.nFrames > 1 && clrCount > clrBase + 1)
            checkEq("frame period", clrHist[clrBase + 1] - clrHist[clrBase], v.expPeriod);
        if (eofCount - eofBase == v.nFrames)
            checkEq("first clr to last eof", eofHist[eofBase + v.nFrames - 1] - clrHist[clrBase], v.expSpan);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [7];
        vec_t v;
        bit   reached;

        // nFrames, stopWithStart, stopAt, stallAt, stallLen, latency, period, span
        vecs[0] = '{1, 1'b1, -1, -1, 0, 10, 0, 10};
        vecs[1] = '{3, 1'b0, -1, -1, 0, 10, 13, 36};
        vecs[2] = '{1, 1'b0, -1, 4, 3, 13, 0, 13};
        vecs[3] = '{2, 1'b0, -1, 0, 1, 11, 14, 24};
        vecs[4] = '{1, 1'b0, -1, 9, 2, 12, 0, 12};
        vecs[5] = '{1, 1'b0, 2, -1, 0, 10, 0, 10};
        vecs[6] = '{2, 1'b0, -1, 7, 1, 11, 14, 24};

        for (int i = 0; i < 1024; i++) srcMem[i] = 1'($urandom_range(0, 1));

        rst_sig           = 1'b1;
        dif.start_sig     = 1'b0;
        dif.stop_sig      = 1'b0;
        dif.mod_ready_sig = 1'b1;
        #1;
        checkEq("reset outputs en/bit/rdy/clr/sof/eof/busy",
                {dif.enc_en_sig, dif.enc_bit_sig, dif.src_ready_sig, dif.enc_clr_sig,
                 dif.sof_sig, dif.eof_sig, dif.busy_sig}, 0);
        checkEq("reset frame_cnt", dif.frame_cnt_sig, 0);
        repeat (2) @(posedge clk_sig);
        #1 rst_sig = 1'b0;
        repeat (3) @(posedge clk_sig);
        #1 checkEq("idle without start", dif.busy_sig, 0);

        for (int i = 0; i < 7; i++) begin
            $display("[TB] scenario %0d: frames=%0d stall@%0d len=%0d stop@%0d", i,
                     vecs[i].nFrames, vecs[i].stallAt, vecs[i].stallLen, vecs[i].stopAt);
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Asynchronous reset in the middle of payload bit 5.
        $display("[TB] reset during payload");
        takeBaselines();
        pushFrames(1);
        @(posedge clk_sig); #1;
        dif.start_sig = 1'b1;
        reached = 0;
        for (int cyc = 0; cyc < 40 && !reached; cyc++) begin
            @(posedge clk_sig); #1;
            dif.start_sig = 1'b0;
            if (clrCount > clrBase && frameEnc == 5) reached = 1;
        end
        checkEq("reached payload bit 5", reached, 1);
        checkEq("enc_en active before reset", dif.enc_en_sig, 1);
        rst_sig = 1'b1;
        #1;
        checkEq("outputs same cycle as reset",
                {dif.enc_en_sig, dif.enc_bit_sig, dif.src_ready_sig, dif.enc_clr_sig,
                 dif.sof_sig, dif.eof_sig, dif.busy_sig}, 0);
        checkEq("frame_cnt cleared by reset", dif.frame_cnt_sig, 0);
        checkEq("wrap frame_cnt cleared by reset", wif.frame_cnt_sig, 0);
        expQ.delete();
        pushIdx     = srcIdx;
        expFrameCnt = 0;
        repeat (2) @(posedge clk_sig);
        #1 rst_sig = 1'b0;
        repeat (2) @(posedge clk_sig);
        #1 checkEq("idle after reset release", dif.busy_sig, 0);

        v = '{1, 1'b1, -1, -1, 0, 10, 0, 10};
        applyStimulus(v);
        checkOutput(v);

        // Three more frames take the 2-bit counter through 1,2,3 back to 0.
        $display("[TB] frame counter wrap");
        v = '{3, 1'b0, -1, -1, 0, 10, 13, 36};
        applyStimulus(v);
        checkOutput(v);
        checkEq("2-bit counter wrapped to zero", wif.frame_cnt_sig, 0);
        checkEq("16-bit counter after four frames", dif.frame_cnt_sig, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
